// File: rtl/spi_reg_responder_if.sv
// SPI pins plus local register side port for spi_reg_responder.
interface spi_reg_responder_if;
  logic       spi_sclk;
  logic       spi_ss_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [4:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_we;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  spi_sclk, spi_ss_n, spi_mosi, loc_addr, loc_wdata, loc_we,
    output spi_miso, spi_miso_oe, loc_rdata, wr_strobe, wr_addr, wr_data, busy
  );

  modport master (
    output spi_sclk, spi_ss_n, spi_mosi, loc_addr, loc_wdata, loc_we,
    input  spi_miso, spi_miso_oe, loc_rdata, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/spi_reg_responder.sv
// Oversampled SPI mode-0 slave fronting a 32x8 register file with a local side port.
// Define SPI_AUTOINC_EN to step the address after every data byte of a burst.
module spi_reg_responder #(
  parameter int unsigned STATUS_ADDR = 25,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_reg_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  localparam logic [4:0] STAT = 5'(STATUS_ADDR);

  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shin_q, shin_d;
  logic [7:0] shout_q, shout_d;
  logic [4:0] addr_q, addr_d;
  logic       dir_q, dir_d;
  logic       miso_q, miso_d;
  logic       oe_q, oe_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] loc_rdata_q, loc_rdata_d;
  logic [7:0] regs_q [32];
  logic [7:0] regs_d [32];

  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [7:0] byte_in;
  logic [4:0] addr_nxt;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
  assign byte_in   = {shin_q, mosi_sync_q[1]};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], bus.spi_sclk};
    ss_sync_d   = {ss_sync_q[1:0], bus.spi_ss_n};
    mosi_sync_d = {mosi_sync_q[0], bus.spi_mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    addr_d      = addr_q;
    dir_d       = dir_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;
    loc_rdata_d = regs_q[bus.loc_addr];
`ifdef SPI_AUTOINC_EN
    addr_nxt    = addr_q + 5'd1;
`else
    addr_nxt    = addr_q;
`endif
    // Local write goes first so a same-address SPI commit below overrides it.
    if (bus.loc_we) regs_d[bus.loc_addr] = bus.loc_wdata;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
          miso_d    = regs_q[STAT][7];
          shout_d   = {regs_q[STAT][6:0], 1'b0};
          oe_d      = 1'b1;
        end
      end
      CMD, DATA: begin
        if (sclk_rise) begin
          shin_d    = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              state_d = DATA;
              addr_d  = byte_in[7:3];
              dir_d   = byte_in[1];
              shout_d = byte_in[1] ? 8'h00 : regs_q[byte_in[7:3]];
            end else begin
              addr_d = addr_nxt;
              if (dir_q) begin
                regs_d[addr_q] = byte_in;
                wr_strobe_d    = 1'b1;
                wr_addr_d      = addr_q;
                wr_data_d      = byte_in;
                shout_d        = 8'h00;
              end else begin
                shout_d = regs_q[addr_nxt];
              end
            end
          end
        end else if (sclk_fall) begin
          // Reload at a byte boundary lands in shout_q before this fall, so MSB goes out here.
          miso_d  = shout_q[7];
          shout_d = {shout_q[6:0], 1'b0};
        end
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          oe_d      = 1'b0;
          miso_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync_q <= 3'b000;
      // Synced ss_n starts low so a frame already in flight at reset never looks like a fresh select.
      ss_sync_q   <= 3'b000;
      mosi_sync_q <= 2'b00;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shin_q      <= 7'd0;
      shout_q     <= 8'd0;
      addr_q      <= 5'd0;
      dir_q       <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'd0;
      loc_rdata_q <= RESET_VAL;
      for (int i = 0; i < 32; i++) regs_q[i] <= RESET_VAL;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      addr_q      <= addr_d;
      dir_q       <= dir_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      loc_rdata_q <= loc_rdata_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.loc_rdata   = loc_rdata_q;
  assign bus.wr_strobe   = wr_strobe_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 slave (CPOL=0, CPHA=0) holding a 32x8 register file, addressed with the same command-byte format the SoC's SPI master uses toward the USB host controller.
- Serves as an in-FPGA stand-in responder and bench target for the SPI master path, so the SoC-side SPI driver code can be exercised without the shield.
- Runs entirely in the system clock domain; SCLK, SS_n and MOSI are oversampled.
- Local logic reads and writes the same register file through a side port.

Parameters:
- STATUS_ADDR, 25: register returned on MISO during the command byte.
- RESET_VAL, 8'h00: reset value of every register.

Ports:
- clk  in  1  system clock (50 MHz); SCLK must be at most clk/8.
- reset_n  in  1  synchronous, active-low reset.
- spi_sclk  in  1  SPI clock from master; asynchronous.
- spi_ss_n  in  1  chip select, active low; asynchronous.
- spi_mosi  in  1  master-out data; asynchronous.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  1 while selected; top level tristates MISO when 0.
- loc_addr  in  5  local register address.
- loc_wdata  in  8  local write data.
- loc_we  in  1  local write strobe.
- loc_rdata  out  8  regfile[loc_addr], registered, 1-cycle latency.
- wr_strobe  out  1  1-cycle pulse when an SPI write commits.
- wr_addr  out  5  address of the committed SPI write.
- wr_data  out  8  data of the committed SPI write.
- busy  out  1  1 while a transaction is in progress (state != IDLE).

Behaviour:
- Synchronisers: two flops each on sclk, ss_n and mosi.
  - Rising and falling SCLK edges are detected from the synced sclk with a third flop.
  - All SPI decisions use the synced signals only.
- Reset: all registers = RESET_VAL; state IDLE; spi_miso=0; spi_miso_oe=0; wr_strobe=0; busy=0; loc_rdata=RESET_VAL; bit counter=0.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synced ss_n falling. Load shift-out register with regfile[STATUS_ADDR] and drive its MSB on spi_miso in the same cycle.
  - CMD: sample MOSI on each SCLK rise, MSB first. After the 8th rise, latch addr=cmd[7:3] and dir=cmd[1] (1=write, 0=read); cmd[2] and cmd[0] are ignored. Go to DATA.
    - dir=0: load shift-out with regfile[addr].
    - dir=1: shift-out = 8'h00.
  - DATA, write: after each 8th rise, commit the byte to regfile[addr]. Pulse wr_strobe for 1 clk with wr_addr/wr_data, one clk after the synced 8th rise.
  - DATA, read: after each 8th rise, reload shift-out with regfile[addr]. Each bytes re-read the current value.
  - Any state -> IDLE on synced ss_n rising.
- MISO shifting: on each SCLK fall, shift out the next bit. A byte boundary reload takes effect before the next fall, so the first bit of each byte is valid before the master's first rise.
- Multi-byte burst: address is held constant (FIFO-style register access) unless AUTOINC_EN is defined.
- Boundary conditions:
  - SS_n deasserts mid-byte: partial byte discarded, no commit, no strobe; bit counter cleared.
  - SS_n deasserts in the same clk as the 8th rise is detected: the byte commits (edge processed first), then IDLE.
  - SPI commit and loc_we to the same address in the same clk: SPI write wins; the local write is dropped.
  - Different addresses in the same clk: both writes occur.
  - Reset mid-transaction: immediate return to reset state. The rest of the frame is ignored until SS_n goes high and then low again.
  - SCLK edges while ss_n is high are ignored.
- Widths: bit counter 3 bits, wraps 7->0; address 5 bits.

Optional Feature:
- Macro: SPI_AUTOINC_EN.
- Defined: in DATA, addr increments by 1 after each full byte, in both read and write. Wraps 31->0. The read reload uses the incremented address.
- Undefined: addr is fixed for the whole frame.

Test Plan:
- Reset, then loc_addr=25 -> loc_rdata=8'h00; busy=0; spi_miso_oe=0.
- Status return: loc_we addr 25 data 8'hA5, then SPI frame cmd 8'h0A, data 8'h3C -> MISO returns A5 during the cmd byte. Then wr_strobe once with wr_addr=1, wr_data=8'h3C; loc_addr=1 reads 3C.
- Read: reg 4=8'h5A, frame cmd 8'h20 + 2 dummy bytes -> MISO returns status, 5A, 5A. No wr_strobe.
- Abort: write frame cmd 8'h12, SS_n raised after 5 data bits -> reg 2 unchanged; no wr_strobe; busy=0 within 3 clks.
- Collision: SPI write 8'h11 to reg 7 coincident with loc_we 8'h22 to reg 7 -> reg 7=8'h11.
- SPI_AUTOINC_EN defined: cmd 8'hFA (addr 31, write), bytes 01, 02 -> reg31=01, reg0=02; two strobes with wr_addr 31 then 0.
